// File: rtl/fdc_sector_buffer_pkg.sv
// rtl/fdc_sector_buffer_pkg.sv - shared FSM state type and sector geometry for the FDC sector buffer
package fdc_sector_buffer_pkg;

    localparam int SECTOR_BYTES = 512;
    localparam int IDX_W        = 9;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CHECK,
        ST_RD_REQ,
        ST_RD_XFER,
        ST_WR_REQ,
        ST_WR_XFER,
        ST_FIN
    } fsm_state_t;

endpackage

// File: rtl/dpram_512x8.sv
// rtl/dpram_512x8.sv - true dual-port 512x8 sector RAM with registered reads
// Port A (addr_a/din_a/we_a/dout_a): SD side, reads every cycle.
// Port B (addr_b/din_b/we_b/re_b/dout_b): FDC side, read only when re_b.
// rst clears only the output registers (to 8'hFF); memory contents survive.
module dpram_512x8 (
    input  logic       clk,
    input  logic       rst,
    input  logic [8:0] addr_a,
    input  logic [7:0] din_a,
    input  logic       we_a,
    output logic [7:0] dout_a,
    input  logic [8:0] addr_b,
    input  logic [7:0] din_b,
    input  logic       we_b,
    input  logic       re_b,
    output logic [7:0] dout_b
);

    logic [7:0] mem [0:511];

    // Both write ports live in one process; on an address collision port B wins.
    always_ff @(posedge clk) begin
        if (we_a) mem[addr_a] <= din_a;
        if (we_b) mem[addr_b] <= din_b;
    end

    // Read-first output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dout_a <= 8'hFF;
            dout_b <= 8'hFF;
        end else begin
            dout_a <= mem[addr_a];
            if (re_b) dout_b <= mem[addr_b];
        end
    end

endmodule

// File: rtl/fdc_sector_buffer.sv
// rtl/fdc_sector_buffer.sv - one-sector buffer between an FDC byte interface and an SD block interface
// Request side : req_read/req_write pulses with req_lba; busy, done (pulse), error (sticky).
// FDC side     : rd_strobe/rd_data, wr_strobe/wr_data, byte_idx, rewind (all ignored while busy).
// SD side      : sd_lba, sd_rd/sd_wr held until sd_ack; sd_buff_* byte stream while sd_ack is high.
// Image        : img_mounted level and img_size in bytes bound the legal lba range.
module fdc_sector_buffer #(
    parameter int SECTOR_BYTES   = fdc_sector_buffer_pkg::SECTOR_BYTES,
    parameter int TIMEOUT_CYCLES = 1048576
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_read,
    input  logic        req_write,
    input  logic [31:0] req_lba,
    output logic        busy,
    output logic        done,
    output logic        error,
    input  logic        rd_strobe,
    output logic [7:0]  rd_data,
    input  logic        wr_strobe,
    input  logic [7:0]  wr_data,
    output logic [8:0]  byte_idx,
    input  logic        rewind,
    output logic [31:0] sd_lba,
    output logic        sd_rd,
    output logic        sd_wr,
    input  logic        sd_ack,
    input  logic [8:0]  sd_buff_addr,
    input  logic [7:0]  sd_buff_dout,
    input  logic        sd_buff_wr,
    output logic [7:0]  sd_buff_din,
    input  logic        img_mounted,
    input  logic [63:0] img_size
);

    import fdc_sector_buffer_pkg::*;

    localparam logic [IDX_W-1:0] LAST_IDX     = IDX_W'(SECTOR_BYTES - 1);
    localparam logic [31:0]      TIMEOUT_LAST = 32'(TIMEOUT_CYCLES - 1);

    fsm_state_t  state;
    logic [31:0] lba;
    logic        is_write;
    logic [31:0] timer;
    logic        rd_en;

    logic fdc_idle;
    logic fdc_we;
    logic sd_we;
    logic unused_size_bits;

    assign fdc_idle = (state == ST_IDLE);
    // rewind outranks the strobes, including suppressing a concurrent write.
    assign fdc_we   = fdc_idle && !rewind && wr_strobe;
    assign sd_we    = (state == ST_RD_XFER) && sd_buff_wr;

    // Only img_size[40:9] (whole sectors) matters for the range check.
    assign unused_size_bits = ^{img_size[63:41], img_size[8:0]};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            error    <= 1'b0;
            sd_rd    <= 1'b0;
            sd_wr    <= 1'b0;
            sd_lba   <= '0;
            lba      <= '0;
            is_write <= 1'b0;
            timer    <= '0;
            byte_idx <= '0;
            rd_en    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (rewind) begin
                        byte_idx <= '0;
                        rd_en    <= 1'b1;
                    end else if (rd_strobe || wr_strobe) begin
                        byte_idx <= (byte_idx == LAST_IDX) ? '0 : byte_idx + 9'd1;
                        rd_en    <= 1'b1;
                    end
                    if (req_read || req_write) begin
                        lba      <= req_lba;
                        is_write <= !req_read;
                        error    <= 1'b0;
                        busy     <= 1'b1;
                        state    <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    timer <= '0;
                    if (!img_mounted || (lba >= img_size[40:9])) begin
                        error <= 1'b1;
                        done  <= 1'b1;
                        state <= ST_FIN;
                    end else begin
                        sd_lba <= lba;
                        if (is_write) begin
                            sd_wr <= 1'b1;
                            state <= ST_WR_REQ;
                        end else begin
                            sd_rd <= 1'b1;
                            state <= ST_RD_REQ;
                        end
                    end
                end
                ST_RD_REQ, ST_WR_REQ: begin
                    if (sd_ack) begin
                        sd_rd <= 1'b0;
                        sd_wr <= 1'b0;
                        state <= (state == ST_RD_REQ) ? ST_RD_XFER : ST_WR_XFER;
                    end else if (timer == TIMEOUT_LAST) begin
                        sd_rd <= 1'b0;
                        sd_wr <= 1'b0;
                        error <= 1'b1;
                        done  <= 1'b1;
                        state <= ST_FIN;
                    end else begin
                        timer <= timer + 32'd1;
                    end
                end
                ST_RD_XFER, ST_WR_XFER: begin
                    // XFER is entered with sd_ack high, so the first low sample is its falling edge.
                    if (!sd_ack) begin
                        done  <= 1'b1;
                        state <= ST_FIN;
                    end
                end
                ST_FIN: begin
                    byte_idx <= '0;
                    rd_en    <= 1'b1;
                    busy     <= 1'b0;
                    state    <= ST_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // rd_en keeps rd_data at its reset value of 8'hFF until the FDC side first moves byte_idx.
    dpram_512x8 u_buf (
        .clk    (clk),
        .rst    (reset),
        .addr_a (sd_buff_addr),
        .din_a  (sd_buff_dout),
        .we_a   (sd_we),
        .dout_a (sd_buff_din),
        .addr_b (byte_idx),
        .din_b  (wr_data),
        .we_b   (fdc_we),
        .re_b   (rd_en),
        .dout_b (rd_data)
    );

endmodule

// File: doc/fdc_sector_buffer.md
FDC_SECTOR_BUFFER -- requirements
Module: fdc_sector_buffer

Interface
REQ-001 SHALL have parameter SECTOR_BYTES, default 512, meaning bytes per sector and buffer depth.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 1048576, meaning the maximum number of cycles to wait for sd_ack before flagging an error.
REQ-003 SHALL have port clk, input, 1, the single system clock.
REQ-004 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-005 SHALL have ports req_read / req_write, input, 1 each, single-cycle sector read / write-back request pulses from the FDC.
REQ-006 SHALL have port req_lba, input, 32, the sector address, sampled on the request pulse.
REQ-007 SHALL have ports busy (out 1), done (out 1, single-cycle pulse), and error (out 1, sticky until the next accepted request).
REQ-008 SHALL have ports rd_strobe (in 1), rd_data (out 8), wr_strobe (in 1), wr_data (in 8), byte_idx (out 9), and rewind (in 1) for FDC byte access.
REQ-009 SHALL have SD-side ports sd_lba (out 32), sd_rd (out 1), sd_wr (out 1), sd_ack (in 1), sd_buff_addr (in 9), sd_buff_dout (in 8), sd_buff_wr (in 1), and sd_buff_din (out 8).
REQ-010 SHALL have ports img_mounted (in 1, level) and img_size (in 64, image size in bytes).

Function
REQ-011 SHALL implement the FSM states IDLE, CHECK, RD_REQ, RD_XFER, WR_REQ, WR_XFER, and FIN.
REQ-012 In IDLE, a req_read pulse SHALL latch req_lba and enter CHECK with the read flag set; req_write SHALL do the same with the write flag; when both are asserted in the same cycle, read SHALL win.
REQ-013 Requests arriving while busy SHALL be ignored.
REQ-014 In CHECK, if img_mounted is 0 or lba >= img_size[40:9], the block SHALL set error and go to FIN without asserting sd_rd or sd_wr; otherwise it SHALL go to RD_REQ or WR_REQ.
REQ-015 In RD_REQ / WR_REQ, the block SHALL hold sd_rd / sd_wr high with sd_lba equal to the latched lba until sd_ack is sampled high, then drop the request and enter XFER.
REQ-016 If sd_ack does not rise within TIMEOUT_CYCLES, the block SHALL set error, drop the request, and go to FIN.
REQ-017 In RD_XFER, each cycle with sd_buff_wr high SHALL write sd_buff_dout into buffer[sd_buff_addr].
REQ-018 In WR_XFER, sd_buff_din SHALL equal buffer[sd_buff_addr] one cycle after that address is presented.
REQ-019 XFER SHALL end on the falling edge of sd_ack, then go to FIN.
REQ-020 FIN SHALL assert done for exactly one cycle, reset byte_idx to 0, and return to IDLE.
REQ-021 busy SHALL be 1 in every state except IDLE.
REQ-022 While idle, rd_strobe SHALL increment byte_idx; rd_data SHALL present buffer[byte_idx] with one-cycle latency after byte_idx changes.
REQ-023 While idle, wr_strobe SHALL write wr_data to buffer[byte_idx] and then increment byte_idx.
REQ-024 When rd_strobe and wr_strobe are asserted together, the write SHALL occur and byte_idx SHALL advance by exactly 1.
REQ-025 byte_idx SHALL wrap from SECTOR_BYTES-1 to 0.
REQ-026 rewind SHALL set byte_idx to 0 and take priority over the strobes.
REQ-027 FDC strobes and rewind SHALL be ignored while busy.
REQ-028 Buffer contents SHALL be retained across requests, including requests that end in error.

Reset
REQ-029 reset SHALL asynchronously force: state to IDLE; busy, done, error, sd_rd, and sd_wr to 0; byte_idx, sd_lba, and the latched lba to 0.
REQ-030 Reset mid-transfer SHALL drop sd_rd and sd_wr immediately and SHALL NOT clear buffer contents.
REQ-031 rd_data after reset SHALL be 8'hFF until the first buffer read completes.

Structure
REQ-032 The FSM state enum and the SECTOR_BYTES constant SHALL reside in the shared MSX package.
REQ-033 The buffer SHALL be one sub-module, dpram_512x8: true dual-port with registered reads, port A on the SD side and port B on the FDC side.
REQ-034 The FSM, timeout counter, and byte index SHALL live in the top module.

Verification
REQ-035 Read: mount a 737280-byte image, pulse req_read with lba=5, then have the SD model ack and stream bytes i^8'hA5 -> exactly one done pulse, error=0, and 512 rd_strobes return 8'hA5, 8'hA4, ... in order.
REQ-036 Out-of-range: req_read with lba=1440 on a 737280-byte image -> error=1, done pulse within 3 cycles, sd_rd never asserted.
REQ-037 Write-back: 512 wr_strobes of data=i[7:0], then req_write with lba=9 -> sd_wr held until ack, and the SD model captures sd_buff_din==addr[7:0] for every address.
REQ-038 Timeout: sd_ack never rises -> error=1 after TIMEOUT_CYCLES, sd_rd low, done pulse.
REQ-039 Boundary: 513 rd_strobes -> byte_idx returns to 1; simultaneous req_read and req_write -> only sd_rd asserted; req_read while busy -> ignored.
REQ-040 Reset mid-RD_XFER -> sd_rd and sd_wr low, busy=0; a subsequent request completes normally.
